// File: rtl/ddr_port1_reader.sv
// ddr_port1_reader
// Reads the display frame buffer out of DDR through MCB user port 1 and
// hands pixels to the video output stage from an internal pixel FIFO.
// It always reads the buffer that the port-0 writer is not filling; the
// buffer is chosen from memory_frame when a display frame starts.
//
// Ports:
//   clk, reset         system clock, asynchronous active-high reset
//   mem_calib_done     MCB calibration done (asynchronous, synchronized here)
//   memory_frame       writer's current frame select
//   frame_start        one-cycle pulse at the start of each display frame
//   pix_rd_en          display pops one pixel
//   pix_data/pix_valid popped pixel {R,G,B}, valid one cycle after the pop
//   underflow          sticky: a pop found the FIFO empty during this frame
//   p1_cmd_*           MCB port-1 command interface (read bursts only)
//   p1_rd_*            MCB port-1 read-data FIFO (first-word-fall-through)
module ddr_port1_reader #(
  parameter int          FRAME_WORDS = 1310720,
  parameter int          BURST_LEN   = 32,
  parameter int          FIFO_DEPTH  = 128,
  parameter logic [29:0] FRAME1_BASE = 30'd5242880
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_calib_done,
  input  logic        memory_frame,
  input  logic        frame_start,
  input  logic        pix_rd_en,
  output logic [23:0] pix_data,
  output logic        pix_valid,
  output logic        underflow,
  input  logic        p1_cmd_full,
  input  logic        p1_rd_empty,
  input  logic [31:0] p1_rd_data,
  output logic        p1_cmd_en,
  output logic [2:0]  p1_cmd_instr,
  output logic [5:0]  p1_cmd_bl,
  output logic [29:0] p1_cmd_byte_addr,
  output logic        p1_rd_en
);

  localparam int RW = $clog2(FRAME_WORDS + 1);  // req_words width
  localparam int AW = $clog2(FIFO_DEPTH);       // FIFO pointer width
  localparam int CW = AW + 1;                   // fill / outstanding width

  localparam logic [RW-1:0] FW_RW    = RW'(FRAME_WORDS);
  localparam logic [RW-1:0] BL_RW    = RW'(BURST_LEN);
  localparam logic [CW-1:0] BL_CW    = CW'(BURST_LEN);
  localparam logic [CW-1:0] DEPTH_CW = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] ZERO_CW  = {CW{1'b0}};
  localparam logic [CW-1:0] ONE_CW   = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [AW-1:0] ONE_AW   = {{(AW-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    ST_INIT       = 3'd0,
    ST_WAIT_FRAME = 3'd1,
    ST_CHECK      = 3'd2,
    ST_CMD        = 3'd3,
    ST_DRAIN      = 3'd4
  } state_t;

  state_t        state_r, state_nxt_s;
  logic          calib_meta_r, calib_sync_r;
  logic [29:0]   base_r;
  logic [RW-1:0] req_words_r;
  logic [CW-1:0] outstanding_r;
  logic          restart_pending_r, restart_frame_r;
  logic          cmd_en_r;
  logic [29:0]   cmd_addr_r;

  logic [23:0]   fifo_mem [0:FIFO_DEPTH-1];
  logic [AW-1:0] wr_ptr_r, rd_ptr_r;
  logic [CW-1:0] fill_r;
  logic [23:0]   pix_data_r;
  logic          pix_valid_r, underflow_r;

  logic          frame_init_s, frame_sel_s, issue_s, rd_pop_s, fifo_wr_s;
  logic          restart_set_s, space_ok_s, pop_ok_s;
  logic [29:0]   req_addr_s;
  logic          unused_s;

  // The upper byte of each MCB word carries no pixel information.
  assign unused_s   = ^p1_rd_data[31:24];
  assign req_addr_s = {{(28-RW){1'b0}}, req_words_r, 2'b00};
  // Room for a whole burst, counting words already requested but not returned.
  assign space_ok_s = ({1'b0, fill_r} + {1'b0, outstanding_r} + {1'b0, BL_CW})
                      <= {1'b0, DEPTH_CW};
  assign pop_ok_s   = pix_rd_en && (fill_r != ZERO_CW);

  // Two-flop synchronizer for the MCB calibration flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      calib_meta_r <= 1'b0;
      calib_sync_r <= 1'b0;
    end else begin
      calib_meta_r <= mem_calib_done;
      calib_sync_r <= calib_meta_r;
    end
  end

  // Next-state logic plus the per-cycle strobes derived from it.
  always_comb begin
    state_nxt_s   = state_r;
    frame_init_s  = 1'b0;
    frame_sel_s   = memory_frame;
    issue_s       = 1'b0;
    rd_pop_s      = 1'b0;
    fifo_wr_s     = 1'b0;
    restart_set_s = 1'b0;
    case (state_r)
      ST_INIT: begin
        if (calib_sync_r) begin
          state_nxt_s = ST_WAIT_FRAME;
        end else begin
          state_nxt_s = ST_INIT;
        end
      end
      ST_WAIT_FRAME: begin
        if (frame_start) begin
          frame_init_s = 1'b1;
          state_nxt_s  = ST_CHECK;
        end else begin
          state_nxt_s  = ST_WAIT_FRAME;
        end
      end
      ST_CHECK: begin
        // Nothing is in flight here, so a restart takes effect at once.
        if (frame_start || restart_pending_r) begin
          frame_init_s = 1'b1;
          frame_sel_s  = frame_start ? memory_frame : restart_frame_r;
          state_nxt_s  = ST_CHECK;
        end else if ((req_words_r == FW_RW) && (outstanding_r == ZERO_CW)) begin
          state_nxt_s  = ST_WAIT_FRAME;
        end else if ((req_words_r < FW_RW) && space_ok_s && !p1_cmd_full) begin
          issue_s      = 1'b1;
          state_nxt_s  = ST_CMD;
        end else begin
          state_nxt_s  = ST_CHECK;
        end
      end
      ST_CMD: begin
        // The burst is already committed; a restart waits for it to drain.
        restart_set_s = frame_start;
        state_nxt_s   = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!p1_rd_empty && (outstanding_r != ZERO_CW)) begin
          rd_pop_s  = 1'b1;
          // Words of a burst that straddles a restart belong to the old frame.
          fifo_wr_s = !(restart_pending_r || frame_start);
        end else begin
          rd_pop_s  = 1'b0;
          fifo_wr_s = 1'b0;
        end
        if ((outstanding_r == ZERO_CW) || ((outstanding_r == ONE_CW) && rd_pop_s)) begin
          state_nxt_s = ST_CHECK;
          if (restart_pending_r || frame_start) begin
            frame_init_s = 1'b1;
            frame_sel_s  = frame_start ? memory_frame : restart_frame_r;
          end else begin
            frame_init_s = 1'b0;
          end
        end else begin
          state_nxt_s   = ST_DRAIN;
          restart_set_s = frame_start;
        end
      end
      default: begin
        state_nxt_s = ST_INIT;
      end
    endcase
  end

  // Control registers: state, frame base, request progress, command outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r           <= ST_INIT;
      base_r            <= 30'd0;
      req_words_r       <= {RW{1'b0}};
      outstanding_r     <= ZERO_CW;
      restart_pending_r <= 1'b0;
      restart_frame_r   <= 1'b0;
      cmd_en_r          <= 1'b0;
      cmd_addr_r        <= 30'd0;
    end else begin
      state_r  <= state_nxt_s;
      cmd_en_r <= issue_s;
      if (issue_s) begin
        cmd_addr_r <= base_r + req_addr_s;
      end
      if (frame_init_s) begin
        // memory_frame=1 means the writer fills buffer 1, so read buffer 0.
        base_r      <= frame_sel_s ? 30'd0 : FRAME1_BASE;
        req_words_r <= {RW{1'b0}};
      end else if (state_r == ST_CMD) begin
        req_words_r <= req_words_r + BL_RW;
      end
      if (state_r == ST_CMD) begin
        outstanding_r <= outstanding_r + BL_CW;
      end else if (rd_pop_s) begin
        outstanding_r <= outstanding_r - ONE_CW;
      end
      if (frame_init_s) begin
        restart_pending_r <= 1'b0;
      end else if (restart_set_s) begin
        restart_pending_r <= 1'b1;
        restart_frame_r   <= memory_frame;
      end
    end
  end

  // Pixel FIFO storage (no reset needed; fill tracks validity).
  always_ff @(posedge clk) begin
    if (fifo_wr_s && !frame_init_s) begin
      fifo_mem[wr_ptr_r] <= p1_rd_data[23:0];
    end
  end

  // Pixel FIFO pointers, fill level and the registered pixel output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r    <= {AW{1'b0}};
      rd_ptr_r    <= {AW{1'b0}};
      fill_r      <= ZERO_CW;
      pix_data_r  <= 24'd0;
      pix_valid_r <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      if (frame_init_s) begin
        wr_ptr_r <= {AW{1'b0}};
        rd_ptr_r <= {AW{1'b0}};
        fill_r   <= ZERO_CW;
      end else begin
        if (fifo_wr_s) begin
          wr_ptr_r <= wr_ptr_r + ONE_AW;
        end
        if (pop_ok_s) begin
          rd_ptr_r <= rd_ptr_r + ONE_AW;
        end
        fill_r <= fill_r + {{(CW-1){1'b0}}, fifo_wr_s} - {{(CW-1){1'b0}}, pop_ok_s};
      end
      if (pop_ok_s) begin
        pix_data_r  <= fifo_mem[rd_ptr_r];
        pix_valid_r <= 1'b1;
      end else begin
        pix_data_r  <= 24'd0;
        pix_valid_r <= 1'b0;
      end
      if (frame_init_s) begin
        underflow_r <= 1'b0;
      end else if (pix_rd_en && !pop_ok_s) begin
        underflow_r <= 1'b1;
      end
    end
  end

  assign p1_cmd_en        = cmd_en_r;
  assign p1_cmd_instr     = 3'b001;
  assign p1_cmd_bl        = 6'(BURST_LEN - 1);
  assign p1_cmd_byte_addr = cmd_addr_r;
  assign p1_rd_en         = rd_pop_s;
  assign pix_data         = pix_data_r;
  assign pix_valid        = pix_valid_r;
  assign underflow        = underflow_r;

endmodule

// File: tb/tb_ddr_port1_reader.sv
// Self-checking bench for ddr_port1_reader with a small MCB port-1 model.
// Expected command addresses and pixel values are queued when a frame is
// started and compared as the DUT issues commands and outputs pixels.
module tb_ddr_port1_reader;
  localparam int          FW = 256;
  localparam int          BL = 32;
  localparam int          DEPTH = 128;
  localparam logic [29:0] B1 = 30'd5242880;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_calib_done = 1'b0;
  logic        memory_frame = 1'b0;
  logic        frame_start = 1'b0;
  logic        pix_rd_en = 1'b0;
  logic [23:0] pix_data;
  logic        pix_valid, underflow;
  logic        p1_cmd_full = 1'b0;
  logic        p1_rd_empty = 1'b1;
  logic [31:0] p1_rd_data = 32'd0;
  logic        p1_cmd_en;
  logic [2:0]  p1_cmd_instr;
  logic [5:0]  p1_cmd_bl;
  logic [29:0] p1_cmd_byte_addr;
  logic        p1_rd_en;

  always #5 clk = ~clk;

  ddr_port1_reader #(.FRAME_WORDS(FW), .BURST_LEN(BL), .FIFO_DEPTH(DEPTH), .FRAME1_BASE(B1)) dut (
    .clk(clk), .reset(reset), .mem_calib_done(mem_calib_done),
    .memory_frame(memory_frame), .frame_start(frame_start), .pix_rd_en(pix_rd_en),
    .pix_data(pix_data), .pix_valid(pix_valid), .underflow(underflow),
    .p1_cmd_full(p1_cmd_full), .p1_rd_empty(p1_rd_empty), .p1_rd_data(p1_rd_data),
    .p1_cmd_en(p1_cmd_en), .p1_cmd_instr(p1_cmd_instr), .p1_cmd_bl(p1_cmd_bl),
    .p1_cmd_byte_addr(p1_cmd_byte_addr), .p1_rd_en(p1_rd_en)
  );

  int          checks = 0;
  int          errors = 0;
  logic [29:0] exp_cmd_q[$];
  logic [23:0] exp_pix_q[$];
  logic [31:0] mcb_q[$];
  int          cmd_count = 0;
  int          mcb_pops = 0;
  int          mcb_delay = 0;
  bit          rd_en_s = 1'b0;
  bit          cmd_en_s = 1'b0;
  bit          prev_cmd_en = 1'b0;
  logic [29:0] cmd_addr_s = 30'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  task automatic push_frame(input logic [29:0] base);
    for (int k = 0; k < FW / BL; k++) exp_cmd_q.push_back(base + 30'(k * BL * 4));
    for (int k = 0; k < FW; k++) exp_pix_q.push_back(24'((base >> 2) + 30'(k)));
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    mem_calib_done = 1'b0;
    frame_start = 1'b0;
    pix_rd_en = 1'b0;
    p1_cmd_full = 1'b0;
    memory_frame = 1'b0;
    exp_cmd_q.delete();
    exp_pix_q.delete();
    tick(3);
    reset = 1'b0;
  endtask

  task automatic bring_up();
    do_reset();
    mem_calib_done = 1'b1;
    tick(4);
  endtask

  // Called at posedge+1; frame_start is high for exactly one cycle.
  task automatic pulse_frame(input bit mf, input bit push, input logic [29:0] base);
    memory_frame = mf;
    frame_start = 1'b1;
    if (push) push_frame(base);
    tick(1);
    frame_start = 1'b0;
  endtask

  task automatic pop_one();
    pix_rd_en = 1'b1;
    tick(1);
    pix_rd_en = 1'b0;
    tick(3);
  endtask

  // Monitor: samples DUT outputs mid-cycle, checks protocol and scoreboards.
  initial forever begin
    @(negedge clk);
    if (reset) begin
      rd_en_s = 1'b0;
      cmd_en_s = 1'b0;
      prev_cmd_en = 1'b0;
    end else begin
      rd_en_s = p1_rd_en;
      cmd_en_s = p1_cmd_en;
      cmd_addr_s = p1_cmd_byte_addr;
      if (p1_rd_en) chk("rd_en_while_empty", 32'(p1_rd_empty), 32'd0);
      if (p1_cmd_en) begin
        cmd_count++;
        chk("cmd_while_full", 32'(p1_cmd_full), 32'd0);
        chk("cmd_back_to_back", 32'(prev_cmd_en), 32'd0);
        chk("cmd_bl", 32'(p1_cmd_bl), 32'd31);
        chk("cmd_instr", 32'(p1_cmd_instr), 32'd1);
        if (exp_cmd_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_cmd: got addr %0d, expected no command at %0t", p1_cmd_byte_addr, $time);
        end else begin
          chk("cmd_addr", 32'(p1_cmd_byte_addr), 32'(exp_cmd_q.pop_front()));
        end
      end
      prev_cmd_en = p1_cmd_en;
      if (pix_valid) begin
        if (exp_pix_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pixel: got %0h, expected no pixel at %0t", pix_data, $time);
        end else begin
          chk("pix_data", 32'(pix_data), 32'(exp_pix_q.pop_front()));
        end
      end
    end
  end

  // MCB port-1 model: each read command returns BL counting words after a delay.
  initial forever begin
    logic [31:0] dummy;
    @(posedge clk);
    #1;
    if (reset) begin
      mcb_q.delete();
      mcb_delay = 0;
      p1_rd_empty = 1'b1;
      p1_rd_data = 32'd0;
    end else begin
      if (rd_en_s && mcb_q.size() > 0) begin
        dummy = mcb_q.pop_front();
        mcb_pops++;
      end
      if (cmd_en_s) begin
        for (int i = 0; i < BL; i++) mcb_q.push_back({8'hA5, 24'((cmd_addr_s >> 2) + 30'(i))});
        mcb_delay = 4;
      end
      if (mcb_delay > 0) mcb_delay--;
      p1_rd_empty = (mcb_q.size() == 0) || (mcb_delay > 0) || ($urandom_range(0, 3) == 0);
      p1_rd_data = (mcb_q.size() > 0) ? mcb_q[0] : 32'hDEADBEEF;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  typedef struct {
    bit          mem_frame;
    int          full_hold;
    logic [29:0] exp_base;
    int          exp_lat;
  } vec_t;

  initial begin
    vec_t vecs[4];
    int   lat, c0, p0, cyc;
    bit   found;

    vecs[0] = '{mem_frame: 1'b1, full_hold: 0,  exp_base: 30'd0, exp_lat: 2};
    vecs[1] = '{mem_frame: 1'b0, full_hold: 0,  exp_base: B1,    exp_lat: 2};
    vecs[2] = '{mem_frame: 1'b1, full_hold: 10, exp_base: 30'd0, exp_lat: 11};
    vecs[3] = '{mem_frame: 1'b0, full_hold: 10, exp_base: B1,    exp_lat: 11};

    // Reset values
    @(negedge clk);
    chk("rst_cmd_en", 32'(p1_cmd_en), 32'd0);
    chk("rst_rd_en", 32'(p1_rd_en), 32'd0);
    chk("rst_cmd_addr", 32'(p1_cmd_byte_addr), 32'd0);
    chk("rst_pix_data", 32'(pix_data), 32'd0);
    chk("rst_pix_valid", 32'(pix_valid), 32'd0);
    chk("rst_underflow", 32'(underflow), 32'd0);
    chk("rst_cmd_instr", 32'(p1_cmd_instr), 32'd1);
    chk("rst_cmd_bl", 32'(p1_cmd_bl), 32'd31);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // frame_start two cycles after calib_done is still seen in INIT
    mem_calib_done = 1'b1;
    tick(2);
    frame_start = 1'b1;
    tick(1);
    frame_start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("init_ignores_frame_start", 32'(p1_cmd_en), 32'd0);
      tick(1);
    end

    // Three cycles after calib_done the reader accepts a frame
    do_reset();
    mem_calib_done = 1'b1;
    tick(3);
    pulse_frame(1'b1, 1'b1, 30'd0);
    @(negedge clk);
    chk("first_cmd_not_early", 32'(p1_cmd_en), 32'd0);
    tick(1);
    @(negedge clk);
    chk("first_cmd_at_fs_plus2", 32'(p1_cmd_en), 32'd1);

    // Table: whole frames with different buffers and command-FIFO stalls
    bring_up();
    for (int v = 0; v < 4; v++) begin
      p1_cmd_full = (vecs[v].full_hold > 0);
      pulse_frame(vecs[v].mem_frame, 1'b1, vecs[v].exp_base);
      cyc = 1;
      found = 1'b0;
      lat = -1;
      while (!found && cyc <= 40) begin
        if (vecs[v].full_hold > 0 && cyc == vecs[v].full_hold) p1_cmd_full = 1'b0;
        @(negedge clk);
        if (p1_cmd_en) begin
          found = 1'b1;
          lat = cyc;
        end else begin
          tick(1);
          cyc++;
        end
      end
      p1_cmd_full = 1'b0;
      chk("first_cmd_latency", 32'(lat), 32'(vecs[v].exp_lat));
      tick(100);
      for (int k = 0; k < FW; k++) pop_one();
      tick(20);
      chk("frame_cmds_left", 32'(exp_cmd_q.size()), 32'd0);
      chk("frame_pix_left", 32'(exp_pix_q.size()), 32'd0);
      chk("frame_underflow", 32'(underflow), 32'd0);
    end

    // FIFO full: four bursts, then a new one only after 32 free slots
    bring_up();
    c0 = cmd_count;
    pulse_frame(1'b1, 1'b1, 30'd0);
    tick(600);
    chk("fill_cmds_full", 32'(cmd_count - c0), 32'd4);
    pop_one();
    tick(200);
    chk("fill_cmds_1_free", 32'(cmd_count - c0), 32'd4);
    for (int k = 0; k < 30; k++) pop_one();
    tick(200);
    chk("fill_cmds_31_free", 32'(cmd_count - c0), 32'd4);
    pop_one();
    tick(200);
    chk("fill_cmds_32_free", 32'(cmd_count - c0), 32'd5);

    // Underflow: sticky until the next frame_start
    bring_up();
    pix_rd_en = 1'b1;
    tick(1);
    pix_rd_en = 1'b0;
    @(negedge clk);
    chk("uf_pix_valid", 32'(pix_valid), 32'd0);
    chk("uf_pix_data", 32'(pix_data), 32'd0);
    chk("uf_set", 32'(underflow), 32'd1);
    tick(5);
    @(negedge clk);
    chk("uf_sticky", 32'(underflow), 32'd1);
    tick(1);
    pulse_frame(1'b1, 1'b1, 30'd0);
    @(negedge clk);
    chk("uf_cleared", 32'(underflow), 32'd0);

    // Restart mid-burst: stale words are dropped, new frame starts at offset 0
    bring_up();
    pulse_frame(1'b1, 1'b1, 30'd0);
    p0 = mcb_pops;
    cyc = 0;
    while ((mcb_pops - p0) < 10 && cyc < 200) begin
      tick(1);
      cyc++;
    end
    chk("restart_burst_started", 32'((mcb_pops - p0) >= 10), 32'd1);
    exp_cmd_q.delete();
    exp_pix_q.delete();
    c0 = cmd_count;
    pulse_frame(1'b0, 1'b1, B1);
    cyc = 0;
    while (cmd_count == c0 && cyc < 200) begin
      tick(1);
      cyc++;
    end
    chk("restart_new_cmd", 32'(cmd_count - c0), 32'd1);
    tick(100);
    for (int k = 0; k < FW; k++) pop_one();
    tick(20);
    chk("restart_cmds_left", 32'(exp_cmd_q.size()), 32'd0);
    chk("restart_pix_left", 32'(exp_pix_q.size()), 32'd0);
    chk("restart_mcb_drained", 32'(mcb_q.size()), 32'd0);
    chk("restart_underflow", 32'(underflow), 32'd0);

    // Reset mid-burst returns to INIT: outputs clear and no command without calib
    bring_up();
    pulse_frame(1'b1, 1'b1, 30'd0);
    tick(8);
    reset = 1'b1;
    exp_cmd_q.delete();
    exp_pix_q.delete();
    @(negedge clk);
    chk("midrst_cmd_en", 32'(p1_cmd_en), 32'd0);
    chk("midrst_rd_en", 32'(p1_rd_en), 32'd0);
    chk("midrst_cmd_addr", 32'(p1_cmd_byte_addr), 32'd0);
    mem_calib_done = 1'b0;
    tick(3);
    reset = 1'b0;
    c0 = cmd_count;
    pulse_frame(1'b1, 1'b0, 30'd0);
    tick(20);
    chk("midrst_stays_init", 32'(cmd_count - c0), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
